// File: rtl/cnna_mac_accum_requant_if.sv
// Product-in / result-out bus of the MAC accumulate + requantise stage.
// The slave modport is the accumulator side; the master modport is the driver/consumer side.
interface cnna_mac_accum_requant_if #(
    parameter int PROD_W = 33,
    parameter int OUT_W  = 16,
    parameter int LEN_W  = 16
);
    logic [LEN_W-1:0]  cfg_len;
    logic [5:0]        cfg_shift;
    logic [PROD_W-1:0] prod_data;
    logic              prod_valid;
    logic              prod_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  cfg_len, cfg_shift, prod_data, prod_valid, out_ready,
        output prod_ready, out_data, out_valid
    );

    modport master (
        output cfg_len, cfg_shift, prod_data, prod_valid, out_ready,
        input  prod_ready, out_data, out_valid
    );
endinterface

// File: rtl/cnna_mac_accum_requant.sv
// Accumulates cfg_len unsigned products, then rounds, shifts and saturates the group sum to OUT_W bits.
// Optional macro CNNA_ACC_SAT_FLAG_EN adds the ovf_sticky / ovf_cnt saturation statistics ports.
module cnna_mac_accum_requant #(
    parameter int PROD_W = 33,
    parameter int ACC_W  = 49,
    parameter int OUT_W  = 16,
    parameter int LEN_W  = 16
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    cnna_mac_accum_requant_if.slave     bus
`ifdef CNNA_ACC_SAT_FLAG_EN
    ,
    output logic                        ovf_sticky,
    output logic [15:0]                 ovf_cnt
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT, S_HOLD} state_t;

    state_t             r_state, w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [LEN_W-1:0]   r_cnt, r_len;
    logic [5:0]         r_shift;
    logic [OUT_W-1:0]   r_out_data;
    logic               r_out_valid;

    logic               w_rdy_st, w_prod_ready, w_beat;
    logic [LEN_W-1:0]   w_len_eff, w_cnt_inc;
    logic [ACC_W:0]     w_rnd, w_sum, w_r;
    logic               w_ovf;
    logic [OUT_W-1:0]   w_sat;

    // A zero length is treated as a single-product group.
    assign w_len_eff    = (bus.cfg_len == '0) ? LEN_W'(1) : bus.cfg_len;
    assign w_cnt_inc    = r_cnt + LEN_W'(1);
    assign w_prod_ready = w_rdy_st & ap_rst_n;
    assign w_beat       = bus.prod_valid & w_prod_ready;

    assign bus.prod_ready = w_prod_ready;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;

    // Round-half-up before the shift; one spare bit keeps acc+rnd from wrapping.
    assign w_rnd = (r_shift == 6'd0) ? '0 : ((ACC_W+1)'(1) << (r_shift - 6'd1));
    assign w_sum = {1'b0, r_acc} + w_rnd;
    assign w_r   = w_sum >> r_shift;
    assign w_ovf = |w_r[ACC_W:OUT_W];
    assign w_sat = w_ovf ? {OUT_W{1'b1}} : w_r[OUT_W-1:0];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rdy_st    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_rdy_st = 1'b1;
                if (w_beat) w_state_nxt = (w_len_eff == LEN_W'(1)) ? S_EMIT : S_ACCUM;
            end
            S_ACCUM: begin
                w_rdy_st = 1'b1;
                if (w_beat && (w_cnt_inc == r_len)) w_state_nxt = S_EMIT;
            end
            S_EMIT:  w_state_nxt = S_HOLD;
            S_HOLD:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_shift     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_beat) begin
                    r_len   <= w_len_eff;
                    r_shift <= bus.cfg_shift;
                    r_acc   <= ACC_W'(bus.prod_data);
                    r_cnt   <= LEN_W'(1);
                end
                S_ACCUM: if (w_beat) begin
                    r_acc <= r_acc + ACC_W'(bus.prod_data);
                    r_cnt <= w_cnt_inc;
                end
                S_EMIT: begin
                    r_out_data  <= w_sat;
                    r_out_valid <= 1'b1;
                end
                S_HOLD: if (bus.out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef CNNA_ACC_SAT_FLAG_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_cnt    <= '0;
        end else if (r_state == S_EMIT && w_ovf) begin
            ovf_sticky <= 1'b1;
            if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cnna_mac_accum_requant.sv
// Scoreboard bench for cnna_mac_accum_requant: expected group results are queued as groups are
// driven and popped when the output handshake completes.
module tb_cnna_mac_accum_requant;
    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    cnna_mac_accum_requant_if bus ();
`ifdef CNNA_ACC_SAT_FLAG_EN
    logic        ovf_sticky;
    logic [15:0] ovf_cnt;
`endif

    cnna_mac_accum_requant dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
`ifdef CNNA_ACC_SAT_FLAG_EN
        ,
        .ovf_sticky (ovf_sticky),
        .ovf_cnt    (ovf_cnt)
`endif
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] sb_q[$];
    int          n_sat = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_r(input logic [63:0] sum, input int sh);
        logic [63:0] r;
        r = sum + ((sh == 0) ? 64'd0 : (64'd1 << (sh - 1)));
        return r >> sh;
    endfunction

    function automatic logic [63:0] model_sat(input logic [63:0] r);
        return (r > 64'd65535) ? 64'd65535 : r;
    endfunction

    always @(negedge ap_clk) begin
        if (ap_rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) chk("sb_underflow", 64'(sb_q.size()), 64'd1);
            else                  chk("sb_out_data", 64'(bus.out_data), sb_q.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] d);
        logic rdy;
        rdy = 1'b0;
        bus.prod_valid = 1'b1;
        bus.prod_data  = d[32:0];
        for (int i = 0; i < 50; i++) begin
            @(negedge ap_clk);
            rdy = bus.prod_ready;
            @(posedge ap_clk);
            #1;
            if (rdy) break;
        end
        chk("beat_accept", 64'(rdy), 64'd1);
        bus.prod_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) cyc(1);
        chk("drain", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_len    = '0;
        bus.cfg_shift  = '0;
        bus.prod_data  = '0;
        bus.prod_valid = 1'b0;
        bus.out_ready  = 1'b1;

        // reset state
        cyc(2);
        @(negedge ap_clk);
        chk("rst_prod_ready", 64'(bus.prod_ready), 64'd0);
        chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
        chk("rst_out_data",   64'(bus.out_data),   64'd0);
        cyc(1);
        ap_rst_n = 1'b1;
        cyc(1);

        // len 3, back-to-back, latency and ready drop in EMIT/HOLD
        bus.cfg_len = 16'd3; bus.cfg_shift = 6'd0;
        beat(64'd10); beat(64'd20);
        sb_q.push_back(64'd60);
        beat(64'd30);
        @(negedge ap_clk);
        chk("emit_out_valid",  64'(bus.out_valid),  64'd0);
        chk("emit_prod_ready", 64'(bus.prod_ready), 64'd0);
        @(negedge ap_clk);
        chk("hold_out_valid",  64'(bus.out_valid),  64'd1);
        chk("hold_prod_ready", 64'(bus.prod_ready), 64'd0);
        chk("hold_out_data",   64'(bus.out_data),   64'd60);
        cyc(1);
        drain();

        // single beat with rounding
        bus.cfg_len = 16'd1; bus.cfg_shift = 6'd4;
        sb_q.push_back(64'd2); beat(64'd24);
        sb_q.push_back(64'd1); beat(64'd23);
        drain();

        // saturation
        bus.cfg_len = 16'd2; bus.cfg_shift = 6'd0;
        sb_q.push_back(64'd65535);
        beat(64'h1_FFFF_FFFF); beat(64'h1_FFFF_FFFF);
        drain();
`ifdef CNNA_ACC_SAT_FLAG_EN
        chk("ovf_sticky_set", 64'(ovf_sticky), 64'd1);
        chk("ovf_cnt_one",    64'(ovf_cnt),    64'd1);
`endif

        // zero length and output backpressure
        bus.out_ready = 1'b0;
        bus.cfg_len = 16'd0; bus.cfg_shift = 6'd0;
        sb_q.push_back(64'd7);
        beat(64'd7);
        cyc(1);
        bus.prod_valid = 1'b1; bus.prod_data = 33'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            chk("bp_out_valid",  64'(bus.out_valid),  64'd1);
            chk("bp_out_data",   64'(bus.out_data),   64'd7);
            chk("bp_prod_ready", 64'(bus.prod_ready), 64'd0);
            cyc(1);
        end
        bus.prod_valid = 1'b0;
        bus.out_ready  = 1'b1;
        drain();

        // reset mid-group, then a clean group
        bus.cfg_len = 16'd4; bus.cfg_shift = 6'd0;
        beat(64'd5); beat(64'd5);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("mrst_prod_ready", 64'(bus.prod_ready), 64'd0);
        chk("mrst_out_valid",  64'(bus.out_valid),  64'd0);
        chk("mrst_out_data",   64'(bus.out_data),   64'd0);
`ifdef CNNA_ACC_SAT_FLAG_EN
        chk("mrst_ovf_sticky", 64'(ovf_sticky), 64'd0);
        chk("mrst_ovf_cnt",    64'(ovf_cnt),    64'd0);
`endif
        cyc(2);
        ap_rst_n = 1'b1;
        cyc(1);
        sb_q.push_back(64'd4);
        for (int i = 0; i < 4; i++) beat(64'd1);
        drain();

        // gapped input, mid-group cfg change ignored
        bus.cfg_len = 16'd2; bus.cfg_shift = 6'd1;
        sb_q.push_back(64'd4);
        beat(64'd3);
        bus.cfg_len = 16'd1; bus.cfg_shift = 6'd0;
        cyc(3);
        beat(64'd4);
        drain();

        // random groups
        for (int g = 0; g < 8; g++) begin
            int          len, sh;
            logic [63:0] sum, d, r;
            len = $urandom_range(1, 5);
            sh  = $urandom_range(0, 20);
            bus.cfg_len = 16'(len); bus.cfg_shift = 6'(sh);
            sum = '0;
            for (int b = 0; b < len; b++) begin
                d = {31'd0, 1'($urandom_range(0, 1)), 32'($urandom)};
                sum += d;
                beat(d);
            end
            r = model_r(sum, sh);
            if (r > 64'd65535) n_sat++;
            sb_q.push_back(model_sat(r));
            drain();
        end
`ifdef CNNA_ACC_SAT_FLAG_EN
        chk("ovf_cnt_final",    64'(ovf_cnt),    64'(n_sat));
        chk("ovf_sticky_final", 64'(ovf_sticky), 64'(n_sat != 0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/cnna_mac_accum_requant.md
Name: cnna_mac_accum_requant

Overview:
- Downstream consumer of the 17ns x 16ns -> 33-bit unsigned multiplier stage in the CNN accelerator datapath.
- Accumulates a group of cfg_len unsigned products, one group per output pixel/channel window.
- Rounds and right-shifts each group sum by cfg_shift, saturates it to OUT_W bits, and presents the result on a valid/ready output register.

Parameters:
- PROD_W, 33, product input width (matches multiplier dout).
- ACC_W, 49, accumulator width; PROD_W+16, so up to 65535 products cannot overflow.
- OUT_W, 16, output width after requantisation.
- LEN_W, 16, width of cfg_len and the beat counter.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- cfg_len  in  LEN_W  products per group; sampled on first beat of each group.
- cfg_shift  in  6  right-shift amount, 0..ACC_W-1; sampled with cfg_len.
- prod_data  in  PROD_W  unsigned product from multiplier.
- prod_valid  in  1  prod_data valid.
- prod_ready  out  1  block accepts prod_data this cycle.
- out_data  out  OUT_W  requantised, saturated group result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Beat = cycle with prod_valid && prod_ready. Output transfer = out_valid && out_ready.
- Reset (async, ap_rst_n=0, any time including mid-group): state=IDLE, acc=0, cnt=0, out_data=0, out_valid=0, prod_ready=0 while reset is asserted, latched cfg=0. Partial group is discarded.
- States:
  - IDLE: prod_ready=1. On a beat: latch len_q = (cfg_len==0 ? 1 : cfg_len) and shift_q=cfg_shift; acc <= prod_data; cnt <= 1. Go to EMIT if len_q==1, else ACCUM.
  - ACCUM: prod_ready=1. On a beat: acc <= acc + prod_data; cnt <= cnt+1. Go to EMIT when cnt+1==len_q. No beat: hold.
  - EMIT: prod_ready=0. One cycle. out_data <= sat(round(acc)); out_valid <= 1; go to HOLD.
  - HOLD: prod_ready=0, out_valid=1, out_data stable. On out_ready: out_valid <= 0, go to IDLE.
- Arithmetic (unsigned, ACC_W+1 bits internally):
  - rnd = shift_q==0 ? 0 : 1<<(shift_q-1).
  - r = (acc + rnd) >> shift_q.
  - sat = r > 2^OUT_W-1 ? 2^OUT_W-1 : r[OUT_W-1:0].
- Latency: last beat at edge t -> acc final at t+1 (EMIT) -> out_valid=1 from edge t+2.
- Throughput: one beat per cycle within a group; minimum 2 idle input cycles per group (EMIT + one HOLD cycle).
- cfg_len/cfg_shift changes mid-group are ignored until the next group's first beat.
- cfg_shift >= ACC_W is illegal; result undefined, no hang.
- prod_valid may drop mid-group; the accumulation gap is indefinite with no timeout.

Optional Feature:
- Macro CNNA_ACC_SAT_FLAG_EN.
- Defined:
  - Extra port ovf_sticky out 1. Set on the EMIT cycle when r > 2^OUT_W-1. Cleared only by reset.
  - Extra port ovf_cnt out 16. Counts saturating groups; saturates at 65535.
- Not defined: ports absent; saturation is silent; no extra registers.

Test Plan:
- cfg_len=3, cfg_shift=0, beats 10,20,30 back-to-back -> out_data=60, out_valid first high 2 cycles after third beat, prod_ready low in EMIT/HOLD.
- cfg_len=1, cfg_shift=4, beat 24 -> (24+8)>>4 = out_data 2; beat 23 -> out_data 1.
- cfg_len=2, cfg_shift=0, two beats of 2^33-1 -> out_data=65535; with CNNA_ACC_SAT_FLAG_EN, ovf_sticky=1 and ovf_cnt=1.
- cfg_len=0, beat 7 -> treated as length 1, out_data=7; then out_ready held low 5 cycles -> out_data/out_valid stable, prod_ready=0, no beats accepted.
- cfg_len=4, 2 beats accepted, ap_rst_n pulsed low mid-cycle -> all outputs 0 immediately; after release a new group of 4 beats of 1 -> out_data=4 with no residue.
- prod_valid gapped (1 beat, 3 idle, 1 beat) with cfg_len=2, shift=1, data 3,4 -> out_data=(7+1)>>1=4.
